// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output-side DAC transmitter.
// FFT_DAC_OFFSET_BIN_EN selects two's-complement to offset-binary conversion at load.
package fft_pkg;
  localparam int DAC_WIDTH = 16;
  localparam int BIT_CNT_W = $clog2(DAC_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} dac_state_t;

  // Word as it enters the shift register.
  function automatic logic [DAC_WIDTH-1:0] dac_load_word(input logic [DAC_WIDTH-1:0] w);
`ifdef FFT_DAC_OFFSET_BIN_EN
    return {~w[DAC_WIDTH-1], w[DAC_WIDTH-2:0]};
`else
    return w;
`endif
  endfunction
endpackage

// File: rtl/fft_tick_gen.sv
// Modulo-DIV counter producing the serial-clock half-period tick.
// Held at zero while disabled so every frame starts on a full half-period.
module fft_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fft_dac_tx.sv
// Three-wire serial DAC transmitter: one 16-bit word per handshake, MSB first.
// Build option FFT_DAC_OFFSET_BIN_EN (see fft_pkg) flips the sign bit at load.
module fft_dac_tx
  import fft_pkg::*;
#(
  parameter int DIV     = 4,
  parameter int CS_HOLD = 2
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [DAC_WIDTH-1:0] iDATA,
  input  logic                 iVALID,
  output logic                 oREADY,
  output logic                 oDONE,
  output logic                 oDAC_DATA,
  output logic                 oDAC_CS,
  output logic                 oDAC_CLK
);
  localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [HW-1:0]        HOLD_LAST = HW'(CS_HOLD - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DAC_WIDTH - 1);

  dac_state_t           state;
  logic [DAC_WIDTH-1:0] shreg;
  logic [DAC_WIDTH-1:0] load_word;
  logic [BIT_CNT_W-1:0] bit_idx;
  logic [HW-1:0]        hold_cnt;
  logic                 tick;

  assign load_word = dac_load_word(iDATA);
  assign oREADY    = (state == IDLE);

  fft_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (iCLK),
    .rst  (iRESET),
    .en   (state == SHIFT),
    .tick (tick)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      hold_cnt  <= '0;
      oDONE     <= 1'b0;
      oDAC_DATA <= 1'b0;
      oDAC_CS   <= 1'b1;
      oDAC_CLK  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (iVALID) begin
          // MSB goes straight to the pin; the register holds the remaining bits.
          state     <= SHIFT;
          oDAC_DATA <= load_word[DAC_WIDTH-1];
          shreg     <= {load_word[DAC_WIDTH-2:0], 1'b0};
          bit_idx   <= '0;
          oDAC_CS   <= 1'b0;
          oDAC_CLK  <= 1'b0;
        end
        SHIFT: if (tick) begin
          if (!oDAC_CLK) begin
            oDAC_CLK <= 1'b1;
          end else begin
            // End of a high phase: data may only move now, with the clock going low.
            oDAC_CLK <= 1'b0;
            if (bit_idx == BIT_LAST) begin
              state     <= HOLD;
              oDAC_CS   <= 1'b1;
              oDAC_DATA <= 1'b0;
              hold_cnt  <= '0;
              oDONE     <= (HOLD_LAST == '0);
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              oDAC_DATA <= shreg[DAC_WIDTH-1];
              shreg     <= {shreg[DAC_WIDTH-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            oDONE <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            oDONE    <= ((hold_cnt + 1'b1) == HOLD_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_dac_tx.sv
// Bench for fft_dac_tx: default instance plus a DIV=1/CS_HOLD=1 instance,
// random words checked against a bus-level view of the frame.
module tb_fft_dac_tx;
`ifdef FFT_DAC_OFFSET_BIN_EN
  localparam logic [15:0] OB = 16'h8000;
`else
  localparam logic [15:0] OB = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vld [2];
  logic [15:0] dat [2];
  logic        rdy [2];
  logic        done[2];
  logic        sd  [2];
  logic        cs  [2];
  logic        sck [2];

  int checks = 0;
  int errors = 0;

  // Observations from the most recent frame capture.
  logic [15:0] cap_word;
  logic        cap_first;
  int cap_rise, cap_low, cap_first_low, cap_done, cap_ndone, cap_ready, cap_hold, cap_viol;

  always #5 clk = ~clk;

  fft_dac_tx u_a (
    .iCLK(clk), .iRESET(rst), .iDATA(dat[0]), .iVALID(vld[0]), .oREADY(rdy[0]),
    .oDONE(done[0]), .oDAC_DATA(sd[0]), .oDAC_CS(cs[0]), .oDAC_CLK(sck[0])
  );

  fft_dac_tx #(.DIV(1), .CS_HOLD(1)) u_b (
    .iCLK(clk), .iRESET(rst), .iDATA(dat[1]), .iVALID(vld[1]), .oREADY(rdy[1]),
    .oDONE(done[1]), .oDAC_DATA(sd[1]), .oDAC_CS(cs[1]), .oDAC_CLK(sck[1])
  );

  // Offer a word and return on the accept edge (cycle 0).
  task automatic start(input int d, input logic [15:0] w);
    @(negedge clk);
    dat[d] = w;
    vld[d] = 1'b1;
    @(posedge clk);
  endtask

  // Watch the bus like the DAC would, one sample per cycle mid-cycle, until oREADY.
  task automatic capture(input int d, input bit keep, input int poke, input int abort_at);
    logic pclk, pdat;
    cap_word = '0; cap_first = 1'bx; cap_rise = 0; cap_low = 0; cap_first_low = -1;
    cap_done = -1; cap_ndone = 0; cap_ready = -1; cap_hold = 0; cap_viol = 0;
    pclk = 1'b0; pdat = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 1 && !keep) vld[d] = 1'b0;
      if (n == poke) begin vld[d] = 1'b1; dat[d] = 16'($urandom); end
      if (n == poke + 1) vld[d] = 1'b0;
      if (n == 1) cap_first = sd[d];
      if (rdy[d] === 1'b1) begin cap_ready = n; break; end
      if (cs[d] === 1'b0) begin
        cap_low++;
        if (cap_first_low < 0) cap_first_low = n;
      end else if (cap_first_low >= 0) cap_hold++;
      if (sck[d] === 1'b1 && pclk === 1'b0) begin
        cap_word = {cap_word[14:0], sd[d]};
        cap_rise++;
      end
      if (sck[d] === 1'b1 && pclk === 1'b1 && sd[d] !== pdat) cap_viol++;
      if (done[d] === 1'b1) begin
        cap_ndone++;
        if (cap_done < 0) cap_done = n;
      end
      pclk = sck[d];
      pdat = sd[d];
      if (n == abort_at) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin vld[d] = 1'b0; dat[d] = '0; end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (cs[d] !== 1'b1)   begin errors++; $display("FAIL reset_cs[%0d] got %b want 1", d, cs[d]); end
      checks++; if (sck[d] !== 1'b0)  begin errors++; $display("FAIL reset_clk[%0d] got %b want 0", d, sck[d]); end
      checks++; if (sd[d] !== 1'b0)   begin errors++; $display("FAIL reset_data[%0d] got %b want 0", d, sd[d]); end
      checks++; if (done[d] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", d, done[d]); end
      checks++; if (rdy[d] !== 1'b1)  begin errors++; $display("FAIL reset_ready[%0d] got %b want 1", d, rdy[d]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || cs[d] !== 1'b1) begin
        errors++; $display("FAIL post_reset_idle[%0d] got rdy=%b cs=%b want 1 1", d, rdy[d], cs[d]);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] exp;
    exp = 16'hA5C3 ^ OB;
    start(0, 16'hA5C3);
    capture(0, 1'b0, -1, -1);
    checks++; if (cap_word !== exp)    begin errors++; $display("FAIL single_word got %h want %h", cap_word, exp); end
    checks++; if (cap_rise != 16)      begin errors++; $display("FAIL single_rises got %0d want 16", cap_rise); end
    checks++; if (cap_first_low != 1)  begin errors++; $display("FAIL single_cs_start got %0d want 1", cap_first_low); end
    checks++; if (cap_first !== exp[15]) begin errors++; $display("FAIL single_msb_c1 got %b want %b", cap_first, exp[15]); end
    checks++; if (cap_low != 128)      begin errors++; $display("FAIL single_cs_low got %0d want 128", cap_low); end
    checks++; if (cap_hold != 2)       begin errors++; $display("FAIL single_hold got %0d want 2", cap_hold); end
    checks++; if (cap_done != 130 || cap_ndone != 1) begin
      errors++; $display("FAIL single_done got cyc %0d cnt %0d want 130 1", cap_done, cap_ndone);
    end
    checks++; if (cap_ready != 131)    begin errors++; $display("FAIL single_ready got %0d want 131", cap_ready); end
    checks++; if (cap_viol != 0)       begin errors++; $display("FAIL single_data_stable got %0d want 0", cap_viol); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'h8000;
    start(0, words[0]);
    for (int i = 0; i < 3; i++) begin
      capture(0, (i < 2), -1, -1);
      checks++; if (cap_word !== (words[i] ^ OB)) begin
        errors++; $display("FAIL b2b_word[%0d] got %h want %h", i, cap_word, words[i] ^ OB);
      end
      checks++; if (cap_ready != 131) begin errors++; $display("FAIL b2b_period[%0d] got %0d want 131", i, cap_ready); end
      checks++; if (cap_hold != 2 || cap_low != 128) begin
        errors++; $display("FAIL b2b_cs[%0d] got hold %0d low %0d want 2 128", i, cap_hold, cap_low);
      end
      if (i < 2) begin
        dat[0] = words[i+1];
        @(posedge clk);
      end
    end
  endtask

  task automatic test_midframe_ignore();
    logic [15:0] w;
    int bad;
    w = 16'($urandom);
    start(0, w);
    capture(0, 1'b0, 40, -1);
    checks++; if (cap_word !== (w ^ OB)) begin errors++; $display("FAIL mid_word got %h want %h", cap_word, w ^ OB); end
    checks++; if (cap_ready != 131)      begin errors++; $display("FAIL mid_ready got %0d want 131", cap_ready); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cs[0] !== 1'b1 || rdy[0] !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_extra_frame got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    int bad;
    start(0, 16'($urandom));
    capture(0, 1'b0, -1, 50);
    rst = 1'b1;
    #1;
    checks++;
    if (cs[0] !== 1'b1 || sck[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++; $display("FAIL async_abort got cs=%b clk=%b rdy=%b want 1 0 1", cs[0], sck[0], rdy[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (cs[0] !== 1'b1 || sck[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL no_resume got %0d busy cycles want 0", bad); end
    w = 16'($urandom);
    start(0, w);
    capture(0, 1'b0, -1, -1);
    checks++;
    if (cap_word !== (w ^ OB) || cap_ready != 131) begin
      errors++; $display("FAIL after_reset_frame got %h/%0d want %h/131", cap_word, cap_ready, w ^ OB);
    end
  endtask

  task automatic test_div1();
    logic [15:0] w;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 16'hA5C3 : 16'($urandom);
      start(1, w);
      capture(1, 1'b0, -1, -1);
      checks++; if (cap_word !== (w ^ OB)) begin errors++; $display("FAIL div1_word[%0d] got %h want %h", i, cap_word, w ^ OB); end
      checks++; if (cap_rise != 16 || cap_low != 32) begin
        errors++; $display("FAIL div1_clk[%0d] got rises %0d low %0d want 16 32", i, cap_rise, cap_low);
      end
      checks++; if (cap_done != 33 || cap_ready != 34) begin
        errors++; $display("FAIL div1_timing[%0d] got done %0d ready %0d want 33 34", i, cap_done, cap_ready);
      end
    end
  endtask

  task automatic test_offset_bin();
    logic [15:0] in_w [2];
    logic [15:0] exp_w [2];
    in_w[0] = 16'h8000; in_w[1] = 16'h7FFF;
`ifdef FFT_DAC_OFFSET_BIN_EN
    exp_w[0] = 16'h0000; exp_w[1] = 16'hFFFF;
`else
    exp_w[0] = 16'h8000; exp_w[1] = 16'h7FFF;
`endif
    for (int i = 0; i < 2; i++) begin
      start(0, in_w[i]);
      capture(0, 1'b0, -1, -1);
      checks++; if (cap_word !== exp_w[i]) begin errors++; $display("FAIL offset_word[%0d] got %h want %h", i, cap_word, exp_w[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      start(0, w);
      capture(0, 1'b0, -1, -1);
      checks++;
      if (cap_word !== (w ^ OB) || cap_done != 130 || cap_viol != 0) begin
        errors++; $display("FAIL rand_frame[%0d] got %h done %0d viol %0d want %h 130 0", i, cap_word, cap_done, cap_viol, w ^ OB);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_midframe_ignore();
    test_reset_midframe();
    test_div1();
    test_offset_bin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
